moore_nonov_seq_det: RTL and testbench

- Moore finite-state machine that detects the serial bit pattern "1010" on a 1-bit input stream, sampling one bit per clock.
- Detection is non-overlapping: once a match completes, the search restarts from scratch. Bits of a completed match are never reused as a prefix of the next match.
- Standalone control block. It sits between a serial data source and downstream logic that consumes a one-cycle detect flag.

---
 rtl/moore_nonov_seq_det_if.sv | 9 +
 rtl/moore_nonov_seq_det.sv | 46 ++++
 tb/tb_moore_nonov_seq_det.sv | 133 +++++++++++++
 3 files changed

// File: rtl/moore_nonov_seq_det_if.sv
// Serial bit stream into the "1010" detector and the one-cycle detect flag out.
// The source holds the master modport; the detector holds the slave modport.
interface moore_nonov_seq_det_if;
  logic in;
  logic out;

  modport master (output in, input out);
  modport slave  (input in, output out);
endinterface

// File: rtl/moore_nonov_seq_det.sv
// Non-overlapping Moore detector for the serial pattern "1010".
// The output comes from the registered state only; the input never reaches it directly.
module moore_nonov_seq_det (
  input  logic                   clk,
  input  logic                   reset,
  moore_nonov_seq_det_if.slave   sif
);

  // Each state is named for the partial match it holds.
  typedef enum logic [2:0] {
    S0 = 3'd0,  // nothing matched
    S1 = 3'd1,  // "1"
    S2 = 3'd2,  // "10"
    S3 = 3'd3,  // "101"
    S4 = 3'd4   // "1010" matched
  } state_t;

  state_t state, state_nxt;

  always_ff @(posedge clk) begin
    if (reset) state <= S0;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = S0;
    sif.out   = 1'b0;
    case (state)
      S0: state_nxt = sif.in ? S1 : S0;
      S1: state_nxt = sif.in ? S1 : S2;
      S2: state_nxt = sif.in ? S3 : S0;
      // A 1 after "101" breaks the match, but that 1 starts a new prefix.
      S3: state_nxt = sif.in ? S1 : S4;
      // Matched bits are never reused: restart from scratch.
      S4: begin
        sif.out   = 1'b1;
        state_nxt = sif.in ? S1 : S0;
      end
      default: begin
        state_nxt = S0;
        sif.out   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_moore_nonov_seq_det.sv
// Scoreboard bench for moore_nonov_seq_det: a bit-history model predicts out
// for every driven bit, and the prediction is popped when the edge has been taken.
module tb_moore_nonov_seq_det;

  logic clk;
  logic reset;
  moore_nonov_seq_det_if sif ();

  moore_nonov_seq_det dut (
    .clk   (clk),
    .reset (reset),
    .sif   (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_chk  = 0;
  int   n_fail = 0;
  logic exp_q[$];
  bit   hist[$];   // bits seen since the last match or reset

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference: pulse when the history since the last restart ends in 1,0,1,0.
  task automatic model(input logic r, input logic b, output logic e);
    int n;
    e = 1'b0;
    if (r) begin
      hist.delete();
    end else begin
      hist.push_back(b);
      n = hist.size();
      if (n >= 4 && hist[n-4] == 1 && hist[n-3] == 0 && hist[n-2] == 1 && hist[n-1] == 0) begin
        e = 1'b1;
        hist.delete();
      end
    end
  endtask

  // Drive one bit (called at a falling edge), predict, sample after the rising edge.
  task automatic step(input string tag, input logic r, input logic b);
    logic e;
    reset  = r;
    sif.in = b;
    model(r, b, e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    else                   chk(tag, {31'd0, sif.out}, {31'd0, exp_q.pop_front()});
    @(negedge clk);
  endtask

  // Apply n bits of v, MSB first, then two idle zeros.
  task automatic run(input string tag, input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) step(tag, 1'b0, v[i]);
    step({tag, "_idle"}, 1'b0, 1'b0);
    step({tag, "_idle"}, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset  = 1'b1;
    sif.in = 1'b0;

    // Reset edge at t=5, release at t=10, then 1,0,1,0 on falling edges 20..50.
    step("reset", 1'b1, 1'b0);
    step("rel",   1'b0, 1'b0);
    step("basic", 1'b0, 1'b1);
    step("basic", 1'b0, 1'b0);
    step("basic", 1'b0, 1'b1);
    reset  = 1'b0;
    sif.in = 1'b0;
    begin
      logic e;
      model(1'b0, 1'b0, e);
      @(posedge clk);
      #1;
      chk("basic_rise_t", 32'($time), 32'd56);
      chk("basic_hit", {31'd0, sif.out}, {31'd0, e});
      @(posedge clk);
      #1;
      chk("basic_fall", {31'd0, sif.out}, 32'd0);
      @(negedge clk);
      model(1'b0, 1'b0, e);
    end

    // Reset for one cycle, then 5 idle zero cycles.
    step("reset2", 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step("idle0", 1'b0, 1'b0);

    run("nonov",  16'b1010_1010, 8);
    run("miss_a", 16'b11010,     5);
    run("miss_b", 16'b10010,     5);
    run("miss_c", 16'b1011010,   7);

    // Reset mid-match discards the "101" prefix.
    step("mid", 1'b0, 1'b1);
    step("mid", 1'b0, 1'b0);
    step("mid", 1'b0, 1'b1);
    step("mid_rst", 1'b1, 1'b0);
    step("mid_after", 1'b0, 1'b0);
    run("mid_next", 16'b1010, 4);

    // Reset on the edge right after reaching S4; then state must behave as S0.
    step("det", 1'b0, 1'b1);
    step("det", 1'b0, 1'b0);
    step("det", 1'b0, 1'b1);
    step("det", 1'b0, 1'b0);
    step("det_rst", 1'b1, 1'b1);
    run("det_s0", 16'b0101_0, 5);

    for (int i = 0; i < 300; i++)
      step("rand", ($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)));

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
